// File: rtl/renode_ahb_sram_subordinate_if.sv
// AHB-Lite bus bundle for renode_ahb_sram_subordinate.
// The master drives the request and data-phase signals; the slave returns ready, response and read data.
interface renode_ahb_sram_subordinate_if #(
    parameter int AddressWidth = 32,
    parameter int DataWidth    = 32
);
    logic                    hsel;
    logic [AddressWidth-1:0] haddr;
    logic [1:0]              htrans;
    logic                    hwrite;
    logic [2:0]              hsize;
    logic [2:0]              hburst;
    logic [DataWidth/8-1:0]  hwstrb;
    logic [DataWidth-1:0]    hwdata;
    logic                    hready;
    logic                    hreadyout;
    logic                    hresp;
    logic [DataWidth-1:0]    hrdata;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hwstrb, hwdata, hready,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hwstrb, hwdata, hready,
        output hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/renode_ahb_sram_subordinate.sv
// AHB-Lite SRAM subordinate with a configurable number of data-phase wait states.
// Define RENODE_AHB_SUBORDINATE_ERROR_RESP_EN to give flagged transfers the two-cycle ERROR response.
module renode_ahb_sram_subordinate #(
    parameter int                      AddressWidth = 32,
    parameter int                      DataWidth    = 32,
    parameter int                      DepthWords   = 256,
    parameter logic [AddressWidth-1:0] BaseAddress  = '0,
    parameter int                      WaitStates   = 0
) (
    input logic                          hclk,
    input logic                          hreset,
    renode_ahb_sram_subordinate_if.slave bus
);
    localparam int NumBytes = DataWidth / 8;
    localparam int LaneBits = $clog2(NumBytes);
    localparam int IdxBits  = $clog2(DepthWords);
    localparam logic [AddressWidth:0] SpanLimit = (AddressWidth + 1)'(DepthWords * NumBytes);

`ifdef RENODE_AHB_SUBORDINATE_ERROR_RESP_EN
    typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_e;
`else
    typedef enum logic {IDLE, DATA} state_e;
`endif

    state_e                        state_q, state_d, start_state;
    logic [3:0]                    wait_q;
    logic [LaneBits+IdxBits-1:0]   addr_q;
    logic                          write_q;
    logic [2:0]                    size_q;
    logic                          err_q;
    logic [DataWidth-1:0]          hrdata_q;

    logic [AddressWidth-1:0]       offset;
    logic [LaneBits-1:0]           size_mask;
    logic                          addr_err;
    logic                          take_addr;
    logic                          ready;
    logic                          resp;
    logic                          complete;
    logic [IdxBits-1:0]            idx;
    logic [DataWidth-1:0]          rd_word;
    logic [NumBytes-1:0]           lane_we;
    logic                          mem_we;
    int                            lane_lo;
    int                            size_bytes;
    logic                          unused_bits;

    logic [DataWidth-1:0] mem [DepthWords];

    assign unused_bits = ^{bus.hburst, bus.htrans[0]};

    // An address below BaseAddress wraps to a huge offset, so one compare covers both ends.
    assign offset    = bus.haddr - BaseAddress;
    assign size_mask = LaneBits'((1 << bus.hsize) - 1);
    assign addr_err  = ({1'b0, offset} >= SpanLimit)
                     || (|(bus.haddr[LaneBits-1:0] & size_mask))
                     || (bus.hsize > 3'(LaneBits));

    assign take_addr = bus.hsel && bus.htrans[1] && bus.hready && ready;
    assign complete  = (state_q == DATA) && (wait_q == '0);

`ifdef RENODE_AHB_SUBORDINATE_ERROR_RESP_EN
    assign start_state = addr_err ? ERR1 : DATA;
`else
    assign start_state = DATA;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (take_addr) state_d = start_state;
            DATA: if (wait_q == '0) state_d = take_addr ? start_state : IDLE;
`ifdef RENODE_AHB_SUBORDINATE_ERROR_RESP_EN
            ERR1: state_d = ERR2;
            ERR2: state_d = take_addr ? start_state : IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b1;
        resp  = 1'b0;
        case (state_q)
            DATA: ready = (wait_q == '0);
`ifdef RENODE_AHB_SUBORDINATE_ERROR_RESP_EN
            ERR1: begin
                ready = 1'b0;
                resp  = 1'b1;
            end
            ERR2: resp = 1'b1;
`endif
            default: ;
        endcase
    end

    // Address-phase capture, wait counter and read-data hold register.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            wait_q   <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= '0;
            err_q    <= 1'b0;
            hrdata_q <= '0;
        end else begin
            if (take_addr) begin
                addr_q  <= offset[LaneBits+IdxBits-1:0];
                write_q <= bus.hwrite;
                size_q  <= bus.hsize;
                err_q   <= addr_err;
                wait_q  <= (start_state == DATA) ? 4'(WaitStates) : 4'd0;
            end else if (state_q == DATA && wait_q != '0) begin
                wait_q <= wait_q - 4'd1;
            end
            if (complete && !write_q) hrdata_q <= rd_word;
        end
    end

    assign idx     = addr_q[LaneBits +: IdxBits];
    assign rd_word = err_q ? '0 : mem[idx];

    // A lane is written only if its strobe is set and it lies inside the hsize-wide window at the address.
    always_comb begin
        lane_lo    = int'(addr_q[LaneBits-1:0]);
        size_bytes = 1 << size_q;
        lane_we    = '0;
        for (int b = 0; b < NumBytes; b++) begin
            if (b >= lane_lo && b < lane_lo + size_bytes) lane_we[b] = bus.hwstrb[b];
        end
    end

    assign mem_we = complete && write_q && !err_q && !hreset;

    // NOTE: the array has no reset; contents survive hreset and it maps onto plain RAM.
    always_ff @(posedge hclk) begin
        if (mem_we) begin
            for (int b = 0; b < NumBytes; b++) begin
                if (lane_we[b]) mem[idx][8*b +: 8] <= bus.hwdata[8*b +: 8];
            end
        end
    end

    assign bus.hreadyout = ready;
    assign bus.hresp     = resp;
    assign bus.hrdata    = hreset ? '0 : ((complete && !write_q) ? rd_word : hrdata_q);
endmodule
